// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter.
// Holds the arbiter state encoding and the engine word width.
package spi_arb_pkg;

    localparam int SPI_DW = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Returns a one-hot winner and its index; valid is low when no request is set.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        valid      = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!valid && req[idx]) begin
                valid           = 1'b1;
                win_onehot[idx] = 1'b1;
                win_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one SPI transaction engine among NREQ requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = SPI_DW,
    parameter int NEWD_CYC = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               spi_newd,
    output logic [DW-1:0]      spi_din,
    input  logic [DW-1:0]      spi_dout,
    input  logic               spi_done
);

    localparam int IW = $clog2(NREQ);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_MAX = (NEWD_CYC > TIMEOUT) ? NEWD_CYC : TIMEOUT;
`else
    localparam int CNT_MAX = NEWD_CYC;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);

    if (NREQ < 2 || NREQ > 8 || NEWD_CYC < 1 || TIMEOUT < 1) begin : g_param_check
        $error("spi_req_arbiter: parameter out of range");
    end

    arb_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic            done_q;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;
    logic            newd_q, newd_d;
    logic [DW-1:0]   din_q, din_d;

    logic            pick_valid;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            done_rise;
    logic            launch_last;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req        (req),
        .ptr        (ptr_q),
        .valid      (pick_valid),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

    assign done_rise   = spi_done & ~done_q;
    assign launch_last = (cnt_q == CW'(NEWD_CYC - 1));
`ifdef SPI_ARB_TIMEOUT_EN
    logic wait_last;
    assign wait_last = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            done_q      <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            newd_q      <= 1'b0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            done_q      <= spi_done;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            newd_q      <= newd_d;
            din_q       <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid)  state_d = LAUNCH;
            LAUNCH:  if (launch_last) state_d = WAIT;
            WAIT: begin
                if (done_rise) state_d = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wait_last) state_d = RESP;
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; every output is a flop.
    always_comb begin
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        newd_d      = 1'b0;
        busy_d      = busy_q;
        din_d       = din_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                din_d  = '0;
                if (pick_valid) begin
                    gnt_d  = pick_onehot;
                    win_d  = pick_idx;
                    din_d  = req_data[pick_idx * DW +: DW];
                    newd_d = 1'b1;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            LAUNCH: begin
                if (launch_last) begin
                    cnt_d = '0;
                end else begin
                    newd_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (done_rise) begin
                    rsp_valid_d = NREQ'(1) << win_q;
                    rsp_data_d  = spi_dout;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wait_last) begin
                    rsp_valid_d = NREQ'(1) << win_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                ptr_d  = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
                busy_d = 1'b0;
                din_d  = '0;
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign spi_newd  = newd_q;
    assign spi_din   = din_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized bench for spi_req_arbiter with a behavioural engine and a timestamp-based reference model.
// Directed scenarios first, then random requesters with a mid-run reset.
module tb_spi_req_arbiter;
    import spi_arb_pkg::*;

    localparam int NREQ     = 4;
    localparam int DW       = SPI_DW;
    localparam int NEWD_CYC = 16;
    localparam int TIMEOUT  = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               spi_newd;
    logic [DW-1:0]      spi_din;
    logic [DW-1:0]      spi_dout = '0;
    logic               spi_done = 1'b0;

    always #5 clk = ~clk;

    spi_req_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .NEWD_CYC (NEWD_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .spi_newd  (spi_newd),
        .spi_din   (spi_din),
        .spi_dout  (spi_dout),
        .spi_done  (spi_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps, not states) ----------------
    logic [NREQ-1:0] exp_gnt  = '0;
    logic [NREQ-1:0] exp_rv   = '0;
    logic [DW-1:0]   exp_data = '0;
    logic [DW-1:0]   exp_din  = '0;
    logic            exp_err  = 1'b0;
    logic            exp_busy = 1'b0;
    logic            exp_newd = 1'b0;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        int            cyc;
        bit            active;
        int            g_cyc;
        int            win_m;
        int            ptr_m;
        int            last_rsp;
        logic          done_prev;
        logic [DW-1:0] din_m;
        logic          rise;
        cyc = 0; active = 0; g_cyc = 0; win_m = 0; ptr_m = 0;
        last_rsp = -10; done_prev = 1'b0; din_m = '0; rise = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            exp_gnt = '0; exp_rv = '0; exp_data = '0; exp_din = '0;
            exp_err = 1'b0; exp_busy = 1'b0; exp_newd = 1'b0;
            if (rst) begin
                active = 0; ptr_m = 0; last_rsp = -10; done_prev = 1'b0;
            end else begin
                rise      = spi_done && !done_prev;
                done_prev = spi_done;
                if (!active && cyc >= last_rsp + 2 && req != '0) begin
                    win_m  = pick(req, ptr_m);
                    active = 1;
                    g_cyc  = cyc;
                    din_m  = req_data[win_m * DW +: DW];
                end
                if (active) begin
                    exp_busy = 1'b1;
                    exp_din  = din_m;
                    exp_newd = (cyc - g_cyc) < NEWD_CYC;
                    if (cyc == g_cyc) exp_gnt[win_m] = 1'b1;
                    if (cyc - 1 >= g_cyc + NEWD_CYC) begin
                        if (rise) begin
                            exp_rv[win_m] = 1'b1;
                            exp_data      = spi_dout;
                            last_rsp      = cyc;
                            ptr_m         = (win_m + 1) % NREQ;
                            active        = 0;
                        end
`ifdef SPI_ARB_TIMEOUT_EN
                        else if (cyc == g_cyc + NEWD_CYC + TIMEOUT) begin
                            exp_rv[win_m] = 1'b1;
                            exp_err       = 1'b1;
                            last_rsp      = cyc;
                            ptr_m         = (win_m + 1) % NREQ;
                            active        = 0;
                        end
`endif
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison and bookkeeping ----------------
    bit collect = 0;
    int order_q[$];
    int gnt_cnt[NREQ];
    int rsp_cnt[NREQ];
    int rsp_total = 0;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            gnt_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            check("gnt",       gnt,       exp_gnt);
            check("rsp_valid", rsp_valid, exp_rv);
            check("rsp_data",  rsp_data,  exp_data);
            check("rsp_err",   rsp_err,   exp_err);
            check("busy",      busy,      exp_busy);
            check("spi_newd",  spi_newd,  exp_newd);
            check("spi_din",   spi_din,   exp_din);
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] === 1'b1) begin
                    gnt_cnt[i]++;
                    if (collect) order_q.push_back(i);
                end
                if (rsp_valid[i] === 1'b1) begin
                    rsp_cnt[i]++;
                    rsp_total++;
                end
            end
        end
    end

    // ---------------- behavioural SPI engine ----------------
    bit echo_only     = 1;
    bit glitch_always = 0;
    bit mute          = 0;

    initial begin
        int            phase;
        int            hi_cnt;
        int            delay;
        int            hold;
        logic [DW-1:0] cap;
        bit            glitch;
        phase = 0; hi_cnt = 0; delay = 0; hold = 0; cap = '0; glitch = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0; spi_done = 1'b0; spi_dout = '0;
            end else begin
                case (phase)
                    0: if (spi_newd) begin
                        cap    = spi_din;
                        hi_cnt = 1;
                        glitch = glitch_always || ($urandom_range(0, 1) == 1);
                        phase  = 1;
                    end
                    1: if (spi_newd) begin
                        hi_cnt++;
                        if (glitch && hi_cnt == 4) begin
                            spi_dout = ~cap;
                            spi_done = 1'b1;
                        end else if (hi_cnt == 5) begin
                            spi_done = 1'b0;
                        end
                    end else begin
                        delay = $urandom_range(0, 8);
                        phase = 2;
                    end
                    2: if (!mute) begin
                        if (delay == 0) begin
                            spi_dout = echo_only ? cap : cap ^ DW'($urandom);
                            spi_done = 1'b1;
                            hold     = 2;
                            phase    = 3;
                        end else begin
                            delay--;
                        end
                    end
                    default: begin
                        hold--;
                        if (hold == 0) begin
                            spi_done = 1'b0;
                            phase    = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input int budget, output int idx, output int lat);
        idx = -1;
        lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                lat = n;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
                break;
            end
        end
        if (idx < 0) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int budget, output logic [DW-1:0] data, output int lat);
        data = '0;
        lat  = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                lat  = n;
                data = rsp_data;
                break;
            end
        end
        if (lat == 0) check("rsp_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int            idx;
        int            lat;
        int            n;
        int            g1_before;
        int            r1_before;
        logic [DW-1:0] d;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // single requester, echoing engine, forced glitch during LAUNCH
        echo_only     = 1;
        glitch_always = 1;
        req_data[2*DW +: DW] = 12'hA5C;
        req[2] = 1'b1;
        wait_gnt(10, idx, lat);
        req[2] = 1'b0;
        check("t1_gnt_idx", idx, 2);
        check("t1_gnt_lat", lat, 1);
        check("t1_spi_din", spi_din, 12'hA5C);
        n = 0;
        while (spi_newd && n < 100) begin
            n++;
            tick(1);
        end
        check("t3_newd_width", n, NEWD_CYC);
        wait_rsp(200, d, lat);
        check("t1_rsp_data", d, 12'hA5C);
        check("t1_rsp_valid", rsp_valid, 4'b0100);
        glitch_always = 0;
        tick(2);
        pulse_reset();

        // contention: all four held for eight transactions
        echo_only = 0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
        collect = 1;
        req = 4'b1111;
        for (int t = 0; t < 8; t++) wait_rsp(200, d, lat);
        req = '0;
        tick(3);
        collect = 0;
        check("t2_order_len", order_q.size(), 8);
        for (int k = 0; k < 8 && k < order_q.size(); k++) check("t2_order", order_q[k], k % NREQ);

        // dropped request while busy
        req[3] = 1'b1;
        wait_gnt(10, idx, lat);
        req[3] = 1'b0;
        check("t4_gnt_idx", idx, 3);
        g1_before = gnt_cnt[1];
        r1_before = rsp_cnt[1];
        tick(3);
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        wait_rsp(200, d, lat);
        tick(5);
        check("t4_no_gnt1", gnt_cnt[1] - g1_before, 0);
        check("t4_no_rsp1", rsp_cnt[1] - r1_before, 0);

        // reset mid-WAIT: pointer moved to 2, then aborted transaction on requester 2
        req[1] = 1'b1;
        wait_gnt(10, idx, lat);
        req[1] = 1'b0;
        wait_rsp(200, d, lat);
        tick(2);
        mute   = 1;
        req[2] = 1'b1;
        wait_gnt(10, idx, lat);
        req[2] = 1'b0;
        tick(NEWD_CYC + 5);
        rst = 1'b1;
        tick(1);
        check("t5_rst_gnt",  gnt,       0);
        check("t5_rst_rsp",  rsp_valid, 0);
        check("t5_rst_busy", busy,      0);
        check("t5_rst_newd", spi_newd,  0);
        check("t5_rst_din",  spi_din,   0);
        rst  = 1'b0;
        mute = 0;
        req  = 4'b1111;
        wait_gnt(10, idx, lat);
        req = '0;
        check("t5_ptr_reset_idx", idx, 0);
        check("t5_gnt_lat", lat, 1);
        wait_rsp(200, d, lat);
        tick(2);

`ifdef SPI_ARB_TIMEOUT_EN
        // engine never completes: watchdog response
        mute   = 1;
        req[0] = 1'b1;
        wait_gnt(10, idx, lat);
        req[0] = 1'b0;
        wait_rsp(NEWD_CYC + TIMEOUT + 50, d, lat);
        check("t6_timeout_lat", lat, NEWD_CYC + TIMEOUT);
        check("t6_rsp_err", rsp_err, 1);
        check("t6_rsp_data", d, 0);
        mute = 0;
        tick(2);
        pulse_reset();
`endif

        // random requesters: hold until granted, sometimes re-request or drop early
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) rst = 1'b1;
            if (c == 1501) rst = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        req_data[i*DW +: DW] = DW'($urandom);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick(1);
        end
        req = '0;
        n = 0;
        while ((busy !== 1'b0) && n < 500) begin
            n++;
            tick(1);
        end
        check("drain_idle", busy, 0);
        check("rand_activity", rsp_total > 40, 1);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
